// File: rtl/counter_pkg.sv
// Shared definitions for the counter family (up-counter and countdown timer).
package counter_pkg;

    localparam int unsigned DEFAULT_WIDTH = 4;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } timer_state_t;

endpackage : counter_pkg

// File: rtl/tick_prescaler.sv
// Divides enabled clock cycles into ticks: one tick every PRESCALE enabled cycles.
module tick_prescaler #(
    parameter int unsigned PRESCALE = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int unsigned CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] count;

    // Tick is combinational so the decrement lands on the same edge the phase wraps.
    assign tick = enable && (count == LAST);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable) begin
            count <= tick ? '0 : count + CW'(1);
        end
    end

endmodule : tick_prescaler

// File: rtl/countdown_timer.sv
// Loadable down-counter: counts q to zero on prescaled ticks, pulses tc, optionally auto-reloads.
module countdown_timer
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH    = DEFAULT_WIDTH,
    parameter int unsigned PRESCALE = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             start,
    input  logic             enable,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             tc
);

    timer_state_t     state;
    logic [WIDTH-1:0] reload_reg;
    logic [WIDTH-1:0] eff_count_c;
    logic             presc_clear_c;
    logic             presc_enable_c;
    logic             tick;

    // Start in the same cycle as load counts from the new value.
    assign eff_count_c    = load ? load_val : q;
    // Prescaler phase is held at zero outside RUN and restarted by any load.
    assign presc_clear_c  = load || (state != RUN);
    assign presc_enable_c = enable && (state == RUN);

    tick_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk    (clk),
        .reset  (reset),
        .clear  (presc_clear_c),
        .enable (presc_enable_c),
        .tick   (tick)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            q          <= '0;
            reload_reg <= '0;
            busy       <= 1'b0;
            tc         <= 1'b0;
        end else begin
            tc <= 1'b0;
            case (state)
                IDLE: begin
                    if (load) begin
                        q          <= load_val;
                        reload_reg <= load_val;
                    end
                    if (start && (eff_count_c != '0)) begin
                        state <= RUN;
                        busy  <= 1'b1;
                    end
                end
                RUN: begin
                    if (load) begin
                        q          <= load_val;
                        reload_reg <= load_val;
                        if (load_val == '0) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else if (tick) begin
                        if (q > WIDTH'(1)) begin
                            q <= q - WIDTH'(1);
                        end else if (q == WIDTH'(1)) begin
                            tc <= 1'b1;
                            if (auto_reload) begin
                                q <= reload_reg;
                            end else begin
                                q     <= '0;
                                state <= IDLE;
                                busy  <= 1'b0;
                            end
                        end else begin
                            // Defensive: never decrement through zero.
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule : countdown_timer

// File: tb/tb_countdown_timer.sv
// Checks two timer instances (PRESCALE 1 and 3) against a cycle-level behavioural model.
module tb_countdown_timer;

    localparam int W = 4;

    logic         clk;
    logic         reset;
    logic         load;
    logic [W-1:0] load_val;
    logic         start;
    logic         enable;
    logic         auto_reload;
    logic [W-1:0] q1, q3;
    logic         busy1, busy3, tc1, tc3;

    int n_checks = 0;
    int n_errors = 0;

    // Model state per instance: index 0 is PRESCALE=1, index 1 is PRESCALE=3.
    int m_q[2];
    int m_rl[2];
    int m_run[2];
    int m_tc[2];
    int m_ph[2];
    int presc[2] = '{1, 3};

    countdown_timer #(.WIDTH(W), .PRESCALE(1)) dut1 (
        .clk(clk), .reset(reset), .load(load), .load_val(load_val), .start(start),
        .enable(enable), .auto_reload(auto_reload), .q(q1), .busy(busy1), .tc(tc1)
    );

    countdown_timer #(.WIDTH(W), .PRESCALE(3)) dut3 (
        .clk(clk), .reset(reset), .load(load), .load_val(load_val), .start(start),
        .enable(enable), .auto_reload(auto_reload), .q(q3), .busy(busy3), .tc(tc3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
        end
    endtask

    // Next-cycle behaviour computed from the current inputs.
    task automatic model_step();
        int lv;
        int eff;
        lv = int'(load_val);
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                m_q[i] = 0; m_rl[i] = 0; m_run[i] = 0; m_tc[i] = 0; m_ph[i] = 0;
            end else begin
                m_tc[i] = 0;
                if (m_run[i] == 0) begin
                    eff = load ? lv : m_q[i];
                    if (load) begin
                        m_q[i]  = lv;
                        m_rl[i] = lv;
                    end
                    m_ph[i] = 0;
                    if (start && eff != 0) m_run[i] = 1;
                end else if (load) begin
                    m_q[i]  = lv;
                    m_rl[i] = lv;
                    m_ph[i] = 0;
                    if (lv == 0) m_run[i] = 0;
                end else if (enable) begin
                    if (m_ph[i] + 1 == presc[i]) begin
                        m_ph[i] = 0;
                        if (m_q[i] == 1) begin
                            m_tc[i] = 1;
                            if (auto_reload) begin
                                m_q[i] = m_rl[i];
                            end else begin
                                m_q[i]   = 0;
                                m_run[i] = 0;
                            end
                        end else if (m_q[i] > 1) begin
                            m_q[i] = m_q[i] - 1;
                        end
                    end else begin
                        m_ph[i] = m_ph[i] + 1;
                    end
                end
            end
        end
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        check("q_p1",    int'(q1),    m_q[0]);
        check("busy_p1", int'(busy1), m_run[0]);
        check("tc_p1",   int'(tc1),   m_tc[0]);
        check("q_p3",    int'(q3),    m_q[1]);
        check("busy_p3", int'(busy3), m_run[1]);
        check("tc_p3",   int'(tc3),   m_tc[1]);
    endtask

    task automatic drive(input logic rst, input logic ld, input int lv, input logic st,
                         input logic en, input logic ar, input int n);
        reset       = rst;
        load        = ld;
        load_val    = W'(lv);
        start       = st;
        enable      = en;
        auto_reload = ar;
        for (int k = 0; k < n; k++) cycle();
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            m_q[i] = 0; m_rl[i] = 0; m_run[i] = 0; m_tc[i] = 0; m_ph[i] = 0;
        end
        reset = 1'b1; load = 1'b0; load_val = '0; start = 1'b0;
        enable = 1'b0; auto_reload = 1'b0;
        #2;

        // Plan 1: reset, load 5, start, run down; start at q=0 ignored.
        drive(1, 0, 0, 0, 0, 0, 2);
        drive(0, 1, 5, 0, 1, 0, 1);
        drive(0, 0, 0, 1, 1, 0, 1);
        drive(0, 0, 0, 0, 1, 0, 5);
        check("p1_expired_q", int'(q1), 0);
        check("p1_expired_tc", int'(tc1), 1);
        drive(0, 0, 0, 0, 1, 0, 12);
        drive(0, 0, 0, 1, 1, 0, 1);
        check("p1_start_at_zero_busy", int'(busy1), 0);
        drive(0, 0, 0, 0, 1, 0, 2);

        // Plan 2: periodic reload of 3, then clear auto_reload.
        drive(0, 1, 3, 1, 1, 1, 1);
        drive(0, 0, 0, 0, 1, 1, 12);
        drive(0, 0, 0, 0, 1, 0, 12);

        // Plan 3: load 2, pause enable for 4 cycles mid-count.
        drive(0, 1, 2, 1, 1, 0, 1);
        drive(0, 0, 0, 0, 1, 0, 2);
        drive(0, 0, 0, 0, 0, 0, 4);
        drive(0, 0, 0, 0, 1, 0, 8);

        // Plan 4: reload in RUN, then load 0 in RUN.
        drive(0, 1, 5, 1, 1, 0, 1);
        drive(0, 0, 0, 0, 1, 0, 3);
        drive(0, 1, 9, 0, 1, 0, 1);
        check("p4_reload_q", int'(q1), 9);
        drive(0, 0, 0, 0, 1, 0, 2);
        drive(0, 1, 0, 0, 1, 0, 1);
        check("p4_load0_busy", int'(busy1), 0);
        check("p4_load0_tc", int'(tc1), 0);

        // Plan 5: load and start in the same cycle, expiry 7 ticks later.
        drive(0, 1, 7, 1, 1, 0, 1);
        drive(0, 0, 0, 0, 1, 0, 24);

        // Plan 6: reset mid-run with auto_reload, then start without load is ignored.
        drive(0, 1, 8, 1, 1, 1, 1);
        drive(0, 0, 0, 0, 1, 1, 4);
        drive(1, 0, 0, 0, 1, 1, 1);
        check("p6_reset_q", int'(q1), 0);
        drive(0, 0, 0, 1, 1, 1, 3);
        check("p6_start_no_load_busy", int'(busy3), 0);

        // Full WIDTH range: 15 ticks.
        drive(0, 1, 15, 1, 1, 0, 1);
        drive(0, 0, 0, 0, 1, 0, 46);

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            drive(($urandom_range(0, 99) < 1),
                  ($urandom_range(0, 99) < 8),
                  int'($urandom_range(0, 15)),
                  ($urandom_range(0, 99) < 20),
                  ($urandom_range(0, 99) < 80),
                  ($urandom_range(0, 99) < 50),
                  1);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_countdown_timer
